// File: rtl/seg_scan_pkg.sv
// Shared types and helpers for the 7-segment/keypad scan sequencer.
package seg_scan_pkg;

  localparam int FRAME_W   = 8;
  localparam int NUM_SLOTS = 4;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT,
    SETTLE,
    SAMPLE,
    DWELL
  } state_e;

  // Frame layout: {keypad row, screen select, digit}; row and screen both follow the slot.
  function automatic logic [FRAME_W-1:0] make_frame(input logic [1:0] slot,
                                                    input logic [3:0] digit);
    return {slot, slot, digit};
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One key's debouncer: the stable state flips after DEBOUNCE_SCANS consecutive disagreeing samples.
module key_debounce #(
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic strobe_i,
  input  logic raw_i,
  output logic state_o,
  output logic flip_o
);

  localparam int CW = $clog2(DEBOUNCE_SCANS) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_SCANS - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          state_q, state_d;

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    cnt_d   = cnt_q;
    state_d = state_q;
    flip_o  = 1'b0;
    if (strobe_i) begin
      if (raw_i == state_q) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
        state_d = ~state_q;
        cnt_d   = '0;
        flip_o  = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // NOTE: non-blocking assignments so every flop updates from the values seen before the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      state_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/seg_scan_ctrl.sv
// Scan sequencer: shifts one frame per slot to the decoder, dwells, and debounces the key line.
module seg_scan_ctrl
  import seg_scan_pkg::*;
#(
  parameter int DWELL_CYCLES   = 1024,
  parameter int SETTLE_CYCLES  = 3,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable_i,
  input  logic [15:0] digits_i,
  input  logic [3:0]  blank_i,
  input  logic        miso_i,
  output logic        mosi_o,
  output logic        en_o,
  output logic [3:0]  key_state_o,
  output logic        key_event_o,
  output logic [1:0]  key_idx_o,
  output logic [1:0]  slot_o,
  output logic        frame_done_o
);

  localparam int DW = $clog2(DWELL_CYCLES) + 1;
  localparam int SW = $clog2(SETTLE_CYCLES) + 1;
  localparam logic [DW-1:0] DWELL_LAST  = DW'(DWELL_CYCLES - 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

  state_e               state_q, state_d;
  logic [1:0]           slot_q, slot_d;
  logic [FRAME_W-1:0]   frame_q, frame_d;
  logic [2:0]           shift_cnt_q, shift_cnt_d;
  logic [SW-1:0]        settle_cnt_q, settle_cnt_d;
  logic [DW-1:0]        dwell_cnt_q, dwell_cnt_d;
  logic                 en_q, en_d, mosi_q, mosi_d, fd_q, fd_d;
  logic                 key_event_q, key_event_d;
  logic [1:0]           key_idx_q, key_idx_d;
  logic [1:0]           miso_sync_q;
  logic                 sample_stb;
  logic [NUM_SLOTS-1:0] key_flip;

  // en_o/mosi_o are computed for the next state so the registered pins line up with state_q.
  always_comb begin
    state_d      = state_q;
    slot_d       = slot_q;
    frame_d      = frame_q;
    shift_cnt_d  = shift_cnt_q;
    settle_cnt_d = settle_cnt_q;
    dwell_cnt_d  = dwell_cnt_q;
    en_d         = 1'b0;
    mosi_d       = 1'b0;
    fd_d         = 1'b0;
    sample_stb   = 1'b0;
    unique case (state_q)
      IDLE: if (enable_i) state_d = LOAD;
      LOAD: begin
        frame_d     = make_frame(slot_q, digits_i[{slot_q, 2'b00} +: 4]);
        shift_cnt_d = '0;
        state_d     = SHIFT;
        en_d        = 1'b1;
        mosi_d      = frame_d[FRAME_W-1];
      end
      SHIFT: begin
        if (shift_cnt_q == 3'd7) begin
          settle_cnt_d = '0;
          state_d      = SETTLE;
        end else begin
          shift_cnt_d = shift_cnt_q + 3'd1;
          frame_d     = frame_q << 1;
          en_d        = 1'b1;
          mosi_d      = frame_d[FRAME_W-1];
        end
      end
      SETTLE: begin
        if (settle_cnt_q == SETTLE_LAST) state_d = SAMPLE;
        else settle_cnt_d = settle_cnt_q + SW'(1);
      end
      SAMPLE: begin
        sample_stb  = 1'b1;
        dwell_cnt_d = '0;
        state_d     = DWELL;
        en_d        = blank_i[slot_q];
      end
      DWELL: begin
        en_d = en_q;
        if (dwell_cnt_q == DWELL_LAST) begin
          en_d    = 1'b0;
          fd_d    = 1'b1;
          slot_d  = slot_q + 2'd1;
          state_d = enable_i ? LOAD : IDLE;
        end else begin
          dwell_cnt_d = dwell_cnt_q + DW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Only the current slot's key sees the strobe, so at most one flip per frame.
  for (genvar k = 0; k < NUM_SLOTS; k++) begin : g_key
    key_debounce #(
      .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
    ) u_debounce (
      .clk     (clk),
      .rst_n   (rst_n),
      .strobe_i(sample_stb && (slot_q == 2'(k))),
      .raw_i   (~miso_sync_q[1]),
      .state_o (key_state_o[k]),
      .flip_o  (key_flip[k])
    );
  end

  assign key_event_d = |key_flip;
  assign key_idx_d   = (|key_flip) ? slot_q : key_idx_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      slot_q       <= '0;
      frame_q      <= '0;
      shift_cnt_q  <= '0;
      settle_cnt_q <= '0;
      dwell_cnt_q  <= '0;
      en_q         <= 1'b0;
      mosi_q       <= 1'b0;
      fd_q         <= 1'b0;
      key_event_q  <= 1'b0;
      key_idx_q    <= '0;
      miso_sync_q  <= '0;
    end else begin
      state_q      <= state_d;
      slot_q       <= slot_d;
      frame_q      <= frame_d;
      shift_cnt_q  <= shift_cnt_d;
      settle_cnt_q <= settle_cnt_d;
      dwell_cnt_q  <= dwell_cnt_d;
      en_q         <= en_d;
      mosi_q       <= mosi_d;
      fd_q         <= fd_d;
      key_event_q  <= key_event_d;
      key_idx_q    <= key_idx_d;
      miso_sync_q  <= {miso_sync_q[0], miso_i};
    end
  end

  assign mosi_o       = mosi_q;
  assign en_o         = en_q;
  assign slot_o       = slot_q;
  assign frame_done_o = fd_q;
  assign key_event_o  = key_event_q;
  assign key_idx_o    = key_idx_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: a decoder model drives miso_i; frames and key events are scoreboarded.
module tb_seg_scan_ctrl;

  localparam int DWELL  = 16;
  localparam int SETTLE = 3;
  localparam int DEB    = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable_i;
  logic [15:0] digits_i;
  logic [3:0]  blank_i;
  logic        miso_i;
  logic        mosi_o, en_o, key_event_o, frame_done_o;
  logic [3:0]  key_state_o;
  logic [1:0]  key_idx_o, slot_o;

  seg_scan_ctrl #(
    .DWELL_CYCLES  (DWELL),
    .SETTLE_CYCLES (SETTLE),
    .DEBOUNCE_SCANS(DEB)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable_i    (enable_i),
    .digits_i    (digits_i),
    .blank_i     (blank_i),
    .miso_i      (miso_i),
    .mosi_o      (mosi_o),
    .en_o        (en_o),
    .key_state_o (key_state_o),
    .key_event_o (key_event_o),
    .key_idx_o   (key_idx_o),
    .slot_o      (slot_o),
    .frame_done_o(frame_done_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       blank;
    logic [7:0] frame;
    logic [1:0] slot;
  } pulse_t;

  typedef struct {
    logic [1:0] idx;
    int         fd;
    logic [3:0] state;
  } evt_t;

  pulse_t pulse_q[$];
  evt_t   evt_q[$];
  int     n_tests = 0;
  int     n_fail  = 0;
  int     fd_cnt  = 0;
  logic [1:0] exp_slot = 2'd0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Decoder model: shifts on clk while en_o is high, latches on en_o fall, keys pull miso_i low.
  logic [7:0] dec_sr    = 8'h00;
  logic [7:0] dec_latch = 8'h00;
  logic [3:0] pressed   = 4'b0000;

  always @(negedge clk) if (en_o) dec_sr <= {dec_sr[6:0], mosi_o};
  always @(negedge en_o) dec_latch = dec_sr;
  assign miso_i = ~pressed[dec_latch[7:6]];

  // Pulse monitor: every en_o high period must match the next scoreboard entry.
  logic       mon_active = 1'b0;
  int         mon_width;
  logic [7:0] mon_data;
  logic       mon_any;
  logic [1:0] mon_slot;
  pulse_t     mon_exp;

  always @(negedge clk) begin
    if (!rst_n) begin
      mon_active = 1'b0;
    end else if (en_o) begin
      if (!mon_active) begin
        mon_active = 1'b1;
        mon_width  = 0;
        mon_data   = '0;
        mon_any    = 1'b0;
        mon_slot   = slot_o;
      end
      mon_width++;
      mon_data = {mon_data[6:0], mosi_o};
      mon_any  = mon_any | mosi_o;
    end else if (mon_active) begin
      mon_active = 1'b0;
      if (pulse_q.size() == 0) begin
        check("spurious_pulse_width", mon_width, 0);
      end else begin
        mon_exp = pulse_q.pop_front();
        check("pulse_slot", mon_slot, mon_exp.slot);
        if (mon_exp.blank) begin
          check("blank_width", mon_width, DWELL);
          check("blank_mosi", mon_any, 0);
        end else begin
          check("frame_width", mon_width, 8);
          check("frame_data", mon_data, mon_exp.frame);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && frame_done_o) begin
      fd_cnt++;
      exp_slot = exp_slot + 2'd1;
      check("slot_after_done", slot_o, exp_slot);
    end
  end

  evt_t ev_exp;
  always @(negedge clk) begin
    if (rst_n && key_event_o) begin
      if (evt_q.size() == 0) begin
        check("spurious_event_idx", key_idx_o, 4);
      end else begin
        ev_exp = evt_q.pop_front();
        check("event_idx", key_idx_o, ev_exp.idx);
        check("event_frame_no", fd_cnt, ev_exp.fd);
        check("event_key_state", key_state_o, ev_exp.state);
      end
    end
  end

  function automatic logic [7:0] exp_frame(input logic [15:0] d, input int s);
    logic [1:0] ss;
    ss = 2'(s);
    return {ss, ss, d[4*s +: 4]};
  endfunction

  task automatic push_slots(input int first, input int n, input logic [15:0] d, input logic [3:0] b);
    pulse_t p;
    for (int i = 0; i < n; i++) begin
      int s;
      s = (first + i) % 4;
      p.blank = 1'b0; p.frame = exp_frame(d, s); p.slot = 2'(s);
      pulse_q.push_back(p);
      if (b[s]) begin
        p.blank = 1'b1; p.frame = 8'h00;
        pulse_q.push_back(p);
      end
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_fd(input int target);
    int t = 0;
    while (fd_cnt < target && t < 5000) begin
      @(negedge clk);
      t++;
    end
    if (fd_cnt < target) check("timeout_frame_done", fd_cnt, target);
  endtask

  task automatic run_slots(input int n);
    int target;
    target   = fd_cnt + n;
    enable_i = 1'b1;
    wait_fd(target - 1);
    enable_i = 1'b0;
    wait_fd(target);
  endtask

  task automatic wait_en_high();
    int t = 0;
    while (!en_o && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!en_o) check("timeout_en_high", en_o, 1);
  endtask

  task automatic check_idle(input string tag, input logic [1:0] slot, input int fd_target);
    tick(40);
    check({tag, "_queue_empty"}, pulse_q.size(), 0);
    check({tag, "_en_idle"}, en_o, 0);
    check({tag, "_slot"}, slot_o, slot);
    check({tag, "_done_count"}, fd_cnt, fd_target);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end

  initial begin
    int base;
    rst_n    = 1'b0;
    enable_i = 1'b0;
    digits_i = 16'h3A71;
    blank_i  = 4'b0000;
    tick(3);
    check("rst_mosi", mosi_o, 0);
    check("rst_en", en_o, 0);
    check("rst_key_state", key_state_o, 0);
    check("rst_key_event", key_event_o, 0);
    check("rst_key_idx", key_idx_o, 0);
    check("rst_slot", slot_o, 0);
    check("rst_frame_done", frame_done_o, 0);
    rst_n = 1'b1;
    tick(2);

    // Two full rounds of plain frames.
    base = fd_cnt;
    begin
      pulse_t p;
      logic [7:0] lit [4];
      lit[0] = 8'h01; lit[1] = 8'h57; lit[2] = 8'hAA; lit[3] = 8'hF3;
      for (int r = 0; r < 2; r++)
        for (int s = 0; s < 4; s++) begin
          p.blank = 1'b0; p.frame = lit[s]; p.slot = 2'(s);
          pulse_q.push_back(p);
        end
    end
    run_slots(8);
    check_idle("p1", 2'd0, base + 8);

    // Slot 2 blanked during its dwell.
    blank_i = 4'b0100;
    base = fd_cnt;
    push_slots(0, 4, digits_i, blank_i);
    run_slots(4);
    check_idle("p2", 2'd0, base + 4);
    blank_i = 4'b0000;

    // Key 1 pressed for only three slot-1 scans: no flip, counter must clear.
    base = fd_cnt;
    pressed = 4'b0010;
    push_slots(0, 16, digits_i, blank_i);
    enable_i = 1'b1;
    wait_fd(base + 12);
    pressed = 4'b0000;
    wait_fd(base + 15);
    enable_i = 1'b0;
    wait_fd(base + 16);
    check_idle("p4", 2'd0, base + 16);
    check("p4_key_state", key_state_o, 4'b0000);
    check("p4_no_event", evt_q.size(), 0);

    // Key 1 held: flips on the 4th slot-1 scan.
    base = fd_cnt;
    pressed = 4'b0010;
    begin
      evt_t e;
      e.idx = 2'd1; e.fd = base + 13; e.state = 4'b0010;
      evt_q.push_back(e);
    end
    push_slots(0, 16, digits_i, blank_i);
    run_slots(16);
    check_idle("p3", 2'd0, base + 16);
    check("p3_key_state", key_state_o, 4'b0010);
    check("p3_event_seen", evt_q.size(), 0);

    // enable_i dropped mid-shift of slot 2: slot 2 still completes.
    base = fd_cnt;
    push_slots(0, 3, digits_i, blank_i);
    enable_i = 1'b1;
    wait_fd(base + 2);
    wait_en_high();
    tick(3);
    enable_i = 1'b0;
    wait_fd(base + 3);
    check_idle("p5", 2'd3, base + 3);

    // Asynchronous reset in the 5th shift cycle of slot 3 (frame 8'hFB, bit 3 is 1).
    digits_i = 16'hB210;
    enable_i = 1'b1;
    wait_en_high();
    tick(4);
    check("p6_pre_en", en_o, 1);
    check("p6_pre_mosi", mosi_o, 1);
    check("p6_pre_key_state", key_state_o, 4'b0010);
    #2 rst_n = 1'b0;
    exp_slot = 2'd0;
    #1;
    check("p6_async_en", en_o, 0);
    check("p6_async_mosi", mosi_o, 0);
    check("p6_async_key_state", key_state_o, 0);
    pressed = 4'b0000;
    tick(3);
    rst_n = 1'b1;
    check("p6_rel_slot", slot_o, 0);
    base = fd_cnt;
    push_slots(0, 4, digits_i, blank_i);
    run_slots(4);
    check_idle("p6", 2'd0, base + 4);
    check("p6_no_event", evt_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
